// File: rtl/expr_eval_if.sv
// rtl/expr_eval_if.sv - character stream in, evaluated result and flags out
interface expr_eval_if #(
    parameter int W = 16
);
    logic [7:0]   in;
    logic         in_valid;
    logic [W-1:0] result;
    logic         out;
    logic         err;
    logic         ovf;

    modport master (
        output in,
        output in_valid,
        input  result,
        input  out,
        input  err,
        input  ovf
    );

    modport slave (
        input  in,
        input  in_valid,
        output result,
        output out,
        output err,
        output ovf
    );
endinterface

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - evaluates single-digit '+'/'*' expressions one character per cycle
module expr_eval #(
    parameter int W = 16
) (
    input  logic      clk,
    input  logic      clr_n,
    expr_eval_if.slave s
);
    typedef enum logic [1:0] {
        S_NUM = 2'd0,
        S_OP  = 2'd1,
        S_ERR = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] prod_q, prod_d;
    logic         mul_q, mul_d;
    logic         ovf_q, ovf_d;

    logic         is_digit;
    logic         is_plus;
    logic         is_star;
    logic [3:0]   digit;
    logic [2*W-1:0] mult_full;
    logic [W:0]     add_full;

    // The low nibble of '0'..'9' is the digit value itself.
    assign digit     = s.in[3:0];
    assign is_digit  = (s.in >= 8'h30) && (s.in <= 8'h39);
    assign is_plus   = (s.in == 8'h2B);
    assign is_star   = (s.in == 8'h2A);
    assign mult_full = {{W{1'b0}}, prod_q} * {{(2*W-4){1'b0}}, digit};
    assign add_full  = {1'b0, sum_q} + {1'b0, prod_q};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_NUM;
            sum_q   <= '0;
            prod_q  <= '0;
            mul_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            prod_q  <= prod_d;
            mul_q   <= mul_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        prod_d  = prod_q;
        mul_d   = mul_q;
        ovf_d   = ovf_q;
        if (s.in_valid) begin
            case (state_q)
                S_NUM: begin
                    if (is_digit) begin
                        if (mul_q) begin
                            prod_d = mult_full[W-1:0];
                            if (mult_full[2*W-1:W] != '0) ovf_d = 1'b1;
                        end else begin
                            prod_d = {{(W-4){1'b0}}, digit};
                        end
                        mul_d   = 1'b0;
                        state_d = S_OP;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_OP: begin
                    if (is_plus) begin
                        sum_d   = add_full[W-1:0];
                        if (add_full[W]) ovf_d = 1'b1;
                        prod_d  = '0;
                        mul_d   = 1'b0;
                        state_d = S_NUM;
                    end else if (is_star) begin
                        mul_d   = 1'b1;
                        state_d = S_NUM;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                default: state_d = S_ERR;
            endcase
        end
    end

    // The displayed sum is not committed, so its carry never reaches ovf.
    always_comb begin
        s.out    = (state_q == S_OP);
        s.err    = (state_q == S_ERR);
        s.ovf    = ovf_q;
        s.result = sum_q + prod_q;
    end
endmodule

// File: tb/tb_expr_eval.sv
// tb/tb_expr_eval.sv - table-driven and directed checks of expr_eval
module tb_expr_eval;
    logic clk;
    logic clr_n;

    expr_eval_if #(.W(16)) bus16();
    expr_eval_if #(.W(8))  bus8();

    expr_eval #(.W(16)) u_dut16 (.clk(clk), .clr_n(clr_n), .s(bus16));
    expr_eval #(.W(8))  u_dut8  (.clk(clk), .clr_n(clr_n), .s(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ch;
        logic        vld;
        logic        rst;
        logic [15:0] res;
        logic        o;
        logic        e;
        logic        v;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic [7:0] ch, input logic vld, input logic rst,
                       input logic [15:0] res, input logic o, input logic e, input logic v);
        vec_t t;
        t.ch = ch; t.vld = vld; t.rst = rst; t.res = res; t.o = o; t.e = e; t.v = v;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] res, input logic o,
                           input logic e, input logic v);
        check({tag, ".result"}, {16'd0, bus16.result}, {16'd0, res});
        check({tag, ".out"},    {31'd0, bus16.out},    {31'd0, o});
        check({tag, ".err"},    {31'd0, bus16.err},    {31'd0, e});
        check({tag, ".ovf"},    {31'd0, bus16.ovf},    {31'd0, v});
    endtask

    task automatic check8(input string tag, input logic [7:0] res, input logic o,
                          input logic e, input logic v);
        check({tag, ".result8"}, {24'd0, bus8.result}, {24'd0, res});
        check({tag, ".out8"},    {31'd0, bus8.out},    {31'd0, o});
        check({tag, ".err8"},    {31'd0, bus8.err},    {31'd0, e});
        check({tag, ".ovf8"},    {31'd0, bus8.ovf},    {31'd0, v});
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] ch, input logic vld);
        bus16.in = ch; bus16.in_valid = vld;
        bus8.in  = ch; bus8.in_valid  = vld;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        bus8.in_valid  = 1'b0;
    endtask

    task automatic send_str(input string str);
        for (int i = 0; i < str.len(); i++) send(str[i], 1'b1);
    endtask

    initial begin
        // "1+2*3"
        add("1", 1, 1, 1, 1, 0, 0);
        add("+", 1, 0, 1, 0, 0, 0);
        add("2", 1, 0, 3, 1, 0, 0);
        add("*", 1, 0, 3, 0, 0, 0);
        add("3", 1, 0, 7, 1, 0, 0);
        // "2*3*4+5" with a two-cycle idle gap before '4'
        add("2", 1, 1, 2, 1, 0, 0);
        add("*", 1, 0, 2, 0, 0, 0);
        add("3", 1, 0, 6, 1, 0, 0);
        add("*", 1, 0, 6, 0, 0, 0);
        add("9", 0, 0, 6, 0, 0, 0);
        add("+", 0, 0, 6, 0, 0, 0);
        add("4", 1, 0, 24, 1, 0, 0);
        add("+", 1, 0, 24, 0, 0, 0);
        add("5", 1, 0, 29, 1, 0, 0);
        // "+1"
        add("+", 1, 1, 0, 0, 1, 0);
        add("1", 1, 0, 0, 0, 1, 0);
        // "12"
        add("1", 1, 1, 1, 1, 0, 0);
        add("2", 1, 0, 1, 0, 1, 0);
        // "3a"
        add("3", 1, 1, 3, 1, 0, 0);
        add("a", 1, 0, 3, 0, 1, 0);
        // "1*" then "0"
        add("1", 1, 1, 1, 1, 0, 0);
        add("*", 1, 0, 1, 0, 0, 0);
        add("0", 1, 0, 0, 1, 0, 0);
        // "9*9*9" fits in 16 bits
        add("9", 1, 1, 9, 1, 0, 0);
        add("*", 1, 0, 9, 0, 0, 0);
        add("9", 1, 0, 81, 1, 0, 0);
        add("*", 1, 0, 81, 0, 0, 0);
        add("9", 1, 0, 729, 1, 0, 0);

        clr_n = 1'b0;
        bus16.in = 8'h00; bus16.in_valid = 1'b0;
        bus8.in  = 8'h00; bus8.in_valid  = 1'b0;
        #12;
        check16("reset", 16'd0, 0, 0, 0);
        check8("reset", 8'd0, 0, 0, 0);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check16("empty", 16'd0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            send(vecs[i].ch, vecs[i].vld);
            check16($sformatf("vec%0d", i), vecs[i].res, vecs[i].o, vecs[i].e, vecs[i].v);
        end

        // 8-bit multiply overflow, then "+0" keeps the flag and value
        do_reset();
        send_str("9*9*9");
        check8("w8_999", 8'd217, 1, 0, 1);
        send_str("+0");
        check8("w8_999p0", 8'd217, 1, 0, 1);

        // 8-bit add carry only counts once '+' commits it
        do_reset();
        send_str("9*9*3+9*9*3");
        check8("w8_disp", 8'd230, 1, 0, 0);
        send("+", 1'b1);
        check8("w8_commit", 8'd230, 0, 0, 1);
        send("0", 1'b1);
        check8("w8_tail", 8'd230, 1, 0, 1);

        // Asynchronous clear between edges
        do_reset();
        send_str("7*8+");
        check16("pre_clr", 16'd56, 0, 0, 0);
        #2;
        clr_n = 1'b0;
        #1;
        check16("async_clr", 16'd0, 0, 0, 0);
        #1;
        clr_n = 1'b1;
        send("5", 1'b1);
        check16("after_clr", 16'd5, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
